apb_timer_irq_ctrl: RTL and testbench
=====================================

APB_TIMER_IRQ_CTRL -- requirements
Module: apb_timer_irq_ctrl

Interface
REQ-001 Parameter APB_ADDR_WIDTH, default 12, SHALL set the PADDR width (4 KB slave).
REQ-002 HCLK  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 HRESET  in  1  SHALL be the reset: asynchronous, active-high.
REQ-004 PADDR  in  APB_ADDR_WIDTH  SHALL be the APB address; only PADDR[3:2] decoded.
REQ-005 PWDATA  in  32  SHALL be the APB write data.
REQ-006 PWRITE, PSEL, PENABLE  in  1 each  SHALL be the APB control signals.
REQ-007 PRDATA  out  32  SHALL be the APB read data.
REQ-008 PREADY  out  1  SHALL be tied to 1.
REQ-009 PSLVERR  out  1  SHALL be tied to 0.
REQ-010 timer_irq_i  in  2  SHALL be the timer event lines: bit0 overflow, bit1 compare match.
REQ-011 irq_o  out  1  SHALL be the interrupt request to the core.
REQ-012 irq_id_o  out  1  SHALL be the source index of the current request.
REQ-013 irq_ack_i  in  1  SHALL be a one-cycle core acknowledge.

Function
REQ-014 A rising edge on timer_irq_i[n], detected against a registered copy, SHALL set PENDING[n] on the next edge; a held-high level SHALL count as one event.
REQ-015 Register map (PADDR[3:2]): 0 PENDING [1:0] read / write-1-to-clear; 1 MASK [1:0] read/write; 2 OVERRUN [1:0] read / write-1-to-clear; 3 COUNT read, any write clears.
REQ-016 Writes SHALL take effect on PSEL&&PENABLE&&PWRITE; PRDATA SHALL equal the addressed register on PSEL&&PENABLE&&!PWRITE, otherwise 0; unused bits SHALL read 0.
REQ-017 An event on source n while PENDING[n]=1 SHALL set OVERRUN[n].
REQ-018 COUNT[15:0] SHALL count overflow events and COUNT[31:16] compare events; each half SHALL saturate at 0xFFFF and never wrap.
REQ-019 If an event and a W1C clear of the same PENDING bit coincide, the set SHALL win; the same applies to OVERRUN.
REQ-020 If an event and a COUNT clear coincide, COUNT SHALL be cleared and then incremented, reading 1 in that half.
REQ-021 FSM states SHALL be IDLE and REQ.
REQ-022 IDLE: if (PENDING&MASK)!=0, latch id (bit1 has priority over bit0) and go to REQ; irq_o=0.
REQ-023 REQ: irq_o=1 and irq_id_o stays equal to the latched id.
REQ-024 REQ with irq_ack_i=1: clear PENDING[id], unless a new event on id arrives that cycle; then go to IDLE.
REQ-025 REQ with PENDING[id] cleared by software or MASK[id] cleared: withdraw to IDLE without ack.
REQ-026 Each return to IDLE SHALL hold irq_o=0 for at least one cycle.
REQ-027 irq_ack_i in IDLE SHALL be ignored.
REQ-028 Latency: a timer edge at cycle t with the source masked-in SHALL give PENDING=1 at t+1 and irq_o=1 at t+2.

Reset
REQ-029 While HRESET=1, PENDING, MASK, OVERRUN, COUNT, the edge registers and irq_id_o SHALL be 0, the FSM SHALL be in IDLE, and irq_o SHALL be 0.
REQ-030 Reset asserted mid-request SHALL drop irq_o immediately (asynchronously) and discard all pending events.

Verification
REQ-031 Set MASK=0x3, pulse timer_irq_i=2'b01 for 1 cycle -> PENDING=0x1 next cycle, irq_o=1 with irq_id_o=0 one cycle later; ack -> PENDING=0, irq_o=0.
REQ-032 Pulse 2'b11 together with MASK=0x3 -> irq_id_o=1 first; after ack, irq_o low for 1 cycle, then irq_o=1 with irq_id_o=0.
REQ-033 Two overflow pulses, no ack -> OVERRUN=0x1 and COUNT=0x00000002; write 0x1 to OVERRUN -> OVERRUN reads 0.
REQ-034 MASK=0, compare pulse -> PENDING=0x2 and irq_o stays 0; then write MASK=0x2 -> irq_o=1 two cycles later; W1C 0x2 to PENDING while in REQ -> irq_o=0 with no ack.
REQ-035 Force 0x10000 compare events -> COUNT[31:16] holds at 0xFFFF; an event coinciding with a COUNT write -> that half reads 1.
REQ-036 Assert HRESET during REQ -> irq_o=0 in the same cycle; every register reads 0 after release.

Source files
------------

// File: rtl/apb_timer_irq_ctrl_if.sv
// rtl/apb_timer_irq_ctrl_if.sv - APB bus bundle for the timer interrupt controller
//
// Purpose: groups the APB slave signals of apb_timer_irq_ctrl.
// Signals:
//   PADDR   [APB_ADDR_WIDTH-1:0]  address (master -> slave)
//   PWDATA  [31:0]                write data (master -> slave)
//   PWRITE, PSEL, PENABLE         control (master -> slave)
//   PRDATA  [31:0]                read data (slave -> master)
//   PREADY, PSLVERR               response (slave -> master)

interface apb_timer_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/apb_timer_irq_ctrl.sv
// rtl/apb_timer_irq_ctrl.sv - timer event latch, counters and interrupt request FSM
//
// Purpose: turns rising edges on two timer event lines into pending bits,
// overrun flags and saturating event counters, and raises a single
// interrupt request (with source id) to the core.
// Ports:
//   HCLK         in   clock, rising edge
//   HRESET       in   asynchronous active-high reset
//   apb          slave modport of apb_timer_irq_ctrl_if (register access)
//   timer_irq_i  in   [1:0] bit0 overflow, bit1 compare match
//   irq_o        out  interrupt request
//   irq_id_o     out  source index of the current request
//   irq_ack_i    in   one-cycle acknowledge from the core
// Registers (PADDR[3:2]): 0 PENDING W1C, 1 MASK RW, 2 OVERRUN W1C,
//   3 COUNT {compare[15:0], overflow[15:0]} any write clears.

module apb_timer_irq_ctrl #(
  parameter int APB_ADDR_WIDTH = 12
) (
  input  logic                        HCLK,
  input  logic                        HRESET,
  apb_timer_irq_ctrl_if.slave         apb,
  input  logic [1:0]                  timer_irq_i,
  output logic                        irq_o,
  output logic                        irq_id_o,
  input  logic                        irq_ack_i
);

  typedef enum logic {IDLE, REQ} state_t;

  state_t      state_q, state_d;
  logic        id_q, id_d;
  logic [1:0]  tmr_q;
  logic [1:0]  pending_q, pending_d;
  logic [1:0]  mask_q, mask_d;
  logic [1:0]  overrun_q, overrun_d;
  logic [15:0] cnt_lo_q, cnt_lo_d;
  logic [15:0] cnt_hi_q, cnt_hi_d;
  logic [1:0]  ack_clr;

  logic [APB_ADDR_WIDTH-1:0] paddr;
  logic [1:0]  sel;
  logic        wr;
  logic        rd;
  logic [1:0]  ev;
  logic [1:0]  w1c_pend;
  logic [1:0]  w1c_ovr;
  logic        cnt_clr;
  logic [15:0] base_lo;
  logic [15:0] base_hi;
  logic [31:0] rdata;
  logic        unused_bits;

  assign paddr       = apb.PADDR;
  assign sel         = paddr[3:2];
  assign wr          = apb.PSEL && apb.PENABLE && apb.PWRITE;
  assign rd          = apb.PSEL && apb.PENABLE && !apb.PWRITE;
  assign unused_bits = ^{paddr[APB_ADDR_WIDTH-1:4], paddr[1:0], apb.PWDATA[31:2]};

  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

  // A held-high line produces exactly one event on its first high cycle.
  assign ev = timer_irq_i & ~tmr_q;

  assign w1c_pend = (wr && sel == 2'd0) ? apb.PWDATA[1:0] : 2'b00;
  assign w1c_ovr  = (wr && sel == 2'd2) ? apb.PWDATA[1:0] : 2'b00;
  assign cnt_clr  = wr && sel == 2'd3;

  // Event set is OR'd in last so it wins over software and ack clears.
  assign pending_d = (pending_q & ~w1c_pend & ~ack_clr) | ev;
  assign overrun_d = (overrun_q & ~w1c_ovr) | (ev & pending_q);
  assign mask_d    = (wr && sel == 2'd1) ? apb.PWDATA[1:0] : mask_q;

  // Clear first, then count, so a coinciding event reads back as 1.
  assign base_lo  = cnt_clr ? 16'd0 : cnt_lo_q;
  assign base_hi  = cnt_clr ? 16'd0 : cnt_hi_q;
  assign cnt_lo_d = (ev[0] && base_lo != 16'hFFFF) ? base_lo + 16'd1 : base_lo;
  assign cnt_hi_d = (ev[1] && base_hi != 16'hFFFF) ? base_hi + 16'd1 : base_hi;

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      tmr_q     <= 2'b00;
      pending_q <= 2'b00;
      mask_q    <= 2'b00;
      overrun_q <= 2'b00;
      cnt_lo_q  <= 16'd0;
      cnt_hi_q  <= 16'd0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      tmr_q     <= timer_irq_i;
      pending_q <= pending_d;
      mask_q    <= mask_d;
      overrun_q <= overrun_d;
      cnt_lo_q  <= cnt_lo_d;
      cnt_hi_q  <= cnt_hi_d;
    end
  end

  // Request FSM. Every exit from REQ lands in IDLE, which always lasts at
  // least one cycle, giving the core a visible low gap between requests.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack_clr = 2'b00;
    case (state_q)
      IDLE: begin
        if ((pending_q & mask_q) != 2'b00) begin
          id_d    = pending_q[1] & mask_q[1];
          state_d = REQ;
        end
      end
      REQ: begin
        if (irq_ack_i) begin
          ack_clr = id_q ? 2'b10 : 2'b01;
          state_d = IDLE;
        end else if (!pending_q[id_q] || !mask_q[id_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decoded straight from the state flop so reset drops the request at once.
  assign irq_o    = (state_q == REQ);
  assign irq_id_o = id_q;

  always_comb begin
    rdata = 32'd0;
    if (rd) begin
      case (sel)
        2'd0:    rdata = {30'd0, pending_q};
        2'd1:    rdata = {30'd0, mask_q};
        2'd2:    rdata = {30'd0, overrun_q};
        default: rdata = {cnt_hi_q, cnt_lo_q};
      endcase
    end
  end

  assign apb.PRDATA = rdata;

endmodule

// File: tb/tb_apb_timer_irq_ctrl.sv
// tb/tb_apb_timer_irq_ctrl.sv - directed self-checking bench for apb_timer_irq_ctrl

module tb_apb_timer_irq_ctrl;

  logic       HCLK;
  logic       HRESET;
  logic [1:0] timer_irq_i;
  logic       irq_o;
  logic       irq_id_o;
  logic       irq_ack_i;
  int         total;
  int         bad;
  logic [31:0] rv;

  apb_timer_irq_ctrl_if #(.APB_ADDR_WIDTH(12)) apb_bus ();

  apb_timer_irq_ctrl #(.APB_ADDR_WIDTH(12)) dut (
    .HCLK        (HCLK),
    .HRESET      (HRESET),
    .apb         (apb_bus.slave),
    .timer_irq_i (timer_irq_i),
    .irq_o       (irq_o),
    .irq_id_o    (irq_id_o),
    .irq_ack_i   (irq_ack_i)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  // Zero-cycle read: PRDATA is combinational during the access phase.
  task automatic peek(input logic [11:0] addr, output logic [31:0] data);
    apb_bus.PADDR   = addr;
    apb_bus.PWRITE  = 1'b0;
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b1;
    #1 data = apb_bus.PRDATA;
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [11:0] addr, input logic [31:0] data);
    apb_bus.PADDR   = addr;
    apb_bus.PWDATA  = data;
    apb_bus.PWRITE  = 1'b1;
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    step();
    apb_bus.PENABLE = 1'b1;
    step();
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
  endtask

  // Write whose access phase coincides with a rising timer edge.
  task automatic write_with_event(input logic [11:0] addr, input logic [31:0] data,
                                  input logic [1:0] tmr);
    apb_bus.PADDR   = addr;
    apb_bus.PWDATA  = data;
    apb_bus.PWRITE  = 1'b1;
    apb_bus.PSEL    = 1'b1;
    apb_bus.PENABLE = 1'b0;
    step();
    apb_bus.PENABLE = 1'b1;
    timer_irq_i     = tmr;
    step();
    apb_bus.PSEL    = 1'b0;
    apb_bus.PENABLE = 1'b0;
    apb_bus.PWRITE  = 1'b0;
    timer_irq_i     = 2'b00;
  endtask

  task automatic pulse(input logic [1:0] tmr);
    timer_irq_i = tmr;
    step();
    timer_irq_i = 2'b00;
  endtask

  task automatic cleanup();
    apb_write(12'h4, 32'h0);
    apb_write(12'h0, 32'h3);
    apb_write(12'h8, 32'h3);
    apb_write(12'hC, 32'h0);
    step();
    step();
  endtask

  task automatic test_reset();
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL rst_irq: got %b want 0", irq_o); end
    total++; if (irq_id_o !== 1'b0) begin bad++; $display("FAIL rst_id: got %b want 0", irq_id_o); end
    total++; if (apb_bus.PREADY !== 1'b1) begin bad++; $display("FAIL pready: got %b want 1", apb_bus.PREADY); end
    total++; if (apb_bus.PSLVERR !== 1'b0) begin bad++; $display("FAIL pslverr: got %b want 0", apb_bus.PSLVERR); end
    HRESET = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      peek(12'(a * 4), rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL rst_reg%0d: got %h want 0", a, rv); end
    end
    apb_bus.PSEL = 1'b1; apb_bus.PENABLE = 1'b0; apb_bus.PADDR = 12'hC;
    #1;
    total++; if (apb_bus.PRDATA !== 32'h0) begin bad++; $display("FAIL idle_prdata: got %h want 0", apb_bus.PRDATA); end
    apb_bus.PSEL = 1'b0;
    step();
  endtask

  task automatic test_basic();
    cleanup();
    apb_write(12'h4, 32'h3);
    pulse(2'b01);
    peek(12'h0, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL basic_pend: got %h want 1", rv); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL basic_irq_t1: got %b want 0", irq_o); end
    step();
    total++; if (irq_o !== 1'b1 || irq_id_o !== 1'b0) begin bad++; $display("FAIL basic_irq_t2: got %b/%b want 1/0", irq_o, irq_id_o); end
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL basic_ack_irq: got %b want 0", irq_o); end
    peek(12'h0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL basic_ack_pend: got %h want 0", rv); end
    peek(12'hC, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL basic_count: got %h want 1", rv); end
  endtask

  task automatic test_priority();
    cleanup();
    apb_write(12'h4, 32'h3);
    pulse(2'b11);
    step();
    total++; if (irq_o !== 1'b1 || irq_id_o !== 1'b1) begin bad++; $display("FAIL prio_first: got %b/%b want 1/1", irq_o, irq_id_o); end
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL prio_gap: got %b want 0", irq_o); end
    step();
    total++; if (irq_o !== 1'b1 || irq_id_o !== 1'b0) begin bad++; $display("FAIL prio_second: got %b/%b want 1/0", irq_o, irq_id_o); end
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    peek(12'h0, rv);
    total++; if (rv !== 32'h0 || irq_o !== 1'b0) begin bad++; $display("FAIL prio_done: got pend=%h irq=%b want 0/0", rv, irq_o); end
    peek(12'hC, rv);
    total++; if (rv !== 32'h00010001) begin bad++; $display("FAIL prio_count: got %h want 00010001", rv); end
  endtask

  task automatic test_overrun();
    cleanup();
    pulse(2'b01); step();
    pulse(2'b01); step();
    peek(12'h8, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL ovr_set: got %h want 1", rv); end
    peek(12'hC, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL ovr_count: got %h want 2", rv); end
    apb_write(12'h8, 32'h1);
    peek(12'h8, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL ovr_clr: got %h want 0", rv); end
  endtask

  task automatic test_mask();
    cleanup();
    pulse(2'b10); step(); step();
    peek(12'h0, rv);
    total++; if (rv !== 32'h2) begin bad++; $display("FAIL mask_pend: got %h want 2", rv); end
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL mask_quiet: got %b want 0", irq_o); end
    apb_write(12'h4, 32'h2);
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL unmask_t1: got %b want 0", irq_o); end
    step();
    total++; if (irq_o !== 1'b1 || irq_id_o !== 1'b1) begin bad++; $display("FAIL unmask_t2: got %b/%b want 1/1", irq_o, irq_id_o); end
    apb_write(12'h0, 32'h2);
    step();
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL w1c_withdraw: got %b want 0", irq_o); end
    peek(12'h0, rv);
    total++; if (rv !== 32'h0) begin bad++; $display("FAIL w1c_pend: got %h want 0", rv); end
  endtask

  task automatic test_ack_idle_and_mask_withdraw();
    cleanup();
    pulse(2'b01); step();
    irq_ack_i = 1'b1; step(); irq_ack_i = 1'b0;
    peek(12'h0, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL idle_ack: got %h want 1", rv); end
    apb_write(12'h4, 32'h1);
    step();
    total++; if (irq_o !== 1'b1 || irq_id_o !== 1'b0) begin bad++; $display("FAIL mw_req: got %b/%b want 1/0", irq_o, irq_id_o); end
    apb_write(12'h4, 32'h0);
    step();
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL mw_withdraw: got %b want 0", irq_o); end
    peek(12'h0, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL mw_pend_kept: got %h want 1", rv); end
  endtask

  task automatic test_coincide();
    cleanup();
    pulse(2'b01); step();
    write_with_event(12'h0, 32'h1, 2'b01);
    peek(12'h0, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL coin_pend: got %h want 1", rv); end
    peek(12'h8, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL coin_ovr_set: got %h want 1", rv); end
    write_with_event(12'h8, 32'h1, 2'b01);
    peek(12'h8, rv);
    total++; if (rv !== 32'h1) begin bad++; $display("FAIL coin_ovr_w1c: got %h want 1", rv); end
    peek(12'hC, rv);
    total++; if (rv !== 32'h3) begin bad++; $display("FAIL coin_count: got %h want 3", rv); end
  endtask

  task automatic test_saturation();
    cleanup();
    force dut.cnt_hi_q = 16'hFFFE;
    step();
    release dut.cnt_hi_q;
    peek(12'hC, rv);
    total++; if (rv !== 32'hFFFE0000) begin bad++; $display("FAIL sat_preload: got %h want fffe0000", rv); end
    pulse(2'b10); step();
    peek(12'hC, rv);
    total++; if (rv !== 32'hFFFF0000) begin bad++; $display("FAIL sat_reach: got %h want ffff0000", rv); end
    for (int i = 0; i < 3; i++) begin
      pulse(2'b10); step();
    end
    peek(12'hC, rv);
    total++; if (rv !== 32'hFFFF0000) begin bad++; $display("FAIL sat_hold: got %h want ffff0000", rv); end
    write_with_event(12'hC, 32'h0, 2'b10);
    peek(12'hC, rv);
    total++; if (rv !== 32'h00010000) begin bad++; $display("FAIL cnt_clr_inc: got %h want 00010000", rv); end
  endtask

  task automatic test_reset_mid_req();
    cleanup();
    apb_write(12'h4, 32'h3);
    pulse(2'b01); step();
    total++; if (irq_o !== 1'b1) begin bad++; $display("FAIL mr_req: got %b want 1", irq_o); end
    timer_irq_i = 2'b10;
    HRESET = 1'b1;
    #1;
    total++; if (irq_o !== 1'b0) begin bad++; $display("FAIL mr_async: got %b want 0", irq_o); end
    step();
    timer_irq_i = 2'b00;
    HRESET = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      peek(12'(a * 4), rv);
      total++; if (rv !== 32'h0) begin bad++; $display("FAIL mr_reg%0d: got %h want 0", a, rv); end
    end
    step();
    total++; if (irq_o !== 1'b0 || irq_id_o !== 1'b0) begin bad++; $display("FAIL mr_after: got %b/%b want 0/0", irq_o, irq_id_o); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    HRESET = 1'b1;
    timer_irq_i = 2'b00;
    irq_ack_i = 1'b0;
    apb_bus.PADDR = '0;
    apb_bus.PWDATA = '0;
    apb_bus.PWRITE = 1'b0;
    apb_bus.PSEL = 1'b0;
    apb_bus.PENABLE = 1'b0;
    step();
    step();
    test_reset();
    test_basic();
    test_priority();
    test_overrun();
    test_mask();
    test_ack_idle_and_mask_withdraw();
    test_coincide();
    test_saturation();
    test_reset_mid_req();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
